// File: rtl/ifid_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl_if
// Groups the hazard information coming from IF/ID and ID/EX, the EX branch
// resolution and memory-stall inputs, and the sequencing controls returned to
// the PC register, IF/ID and ID/EX.
//   master : pipeline side. Drives hazard/branch/stall info and receives the
//            enables, flushes, redirect and performance counters.
//   slave  : the hazard controller itself.
// ---------------------------------------------------------------------------
interface ifid_hazard_ctrl_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
);
    // Hazard / control inputs to the controller
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ifid_use_rs1;
    logic             ifid_use_rs2;
    logic [4:0]       idex_rd;
    logic             idex_mem_read;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             ext_stall;

    // Sequencing outputs from the controller
    logic             pc_write;
    logic             pc_redirect;
    logic [XLEN-1:0]  redirect_target;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_rd, idex_mem_read, branch_taken, branch_target, ext_stall,
        input  pc_write, pc_redirect, redirect_target, ifid_write,
               ifid_flush, idex_flush, stall_count, flush_count
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_rd, idex_mem_read, branch_taken, branch_target, ext_stall,
        output pc_write, pc_redirect, redirect_target, ifid_write,
               ifid_flush, idex_flush, stall_count, flush_count
    );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl
// Front-end sequencing controller sitting beside IF/ID. Detects load-use
// hazards (stall + ID/EX bubble), applies taken-branch redirects (flush
// IF/ID and ID/EX), freezes the front end on external memory stall while
// remembering the first redirect seen during the freeze, and keeps saturating
// stall/flush performance counters.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   io_hz  : hazard/branch/stall inputs and sequencing outputs (slave side)
// Outputs respond combinationally to state and inputs; state, pending
// redirect target and counters are registered.
// ---------------------------------------------------------------------------
module ifid_hazard_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    ifid_hazard_ctrl_if.slave    io_hz
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_HOLD_RD = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_next_state;
    logic [XLEN-1:0]  r_pend_target;
    logic [XLEN-1:0]  w_pend_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_load_use;
    logic             w_pc_write;
    logic             w_pc_redirect;
    logic [XLEN-1:0]  w_redirect_target;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_idex_flush;
    logic             w_stall_evt;
    logic             w_flush_evt;

    // Load in EX whose destination is a live source of the instruction in ID
    assign w_load_use = io_hz.idex_mem_read && (io_hz.idex_rd != 5'd0) &&
                        ((io_hz.ifid_use_rs1 && (io_hz.idex_rd == io_hz.ifid_rs1)) ||
                         (io_hz.ifid_use_rs2 && (io_hz.idex_rd == io_hz.ifid_rs2)));

    // State register, pending redirect target and saturating counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_pend_target <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state       <= w_next_state;
            r_pend_target <= w_pend_next;
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and sequencing outputs
    always_comb begin
        w_next_state      = r_state;
        w_pend_next       = r_pend_target;
        w_pc_write        = 1'b1;
        w_ifid_write      = 1'b1;
        w_ifid_flush      = 1'b0;
        w_idex_flush      = 1'b0;
        w_pc_redirect     = 1'b0;
        w_redirect_target = (r_state == ST_HOLD_RD) ? r_pend_target : io_hz.branch_target;
        w_stall_evt       = 1'b0;
        w_flush_evt       = 1'b0;

        case (r_state)
            // HOLD without ext_stall behaves exactly like RUN, so they share a branch
            ST_RUN, ST_HOLD: begin
                w_next_state = ST_RUN;
                if (io_hz.branch_taken && !io_hz.ext_stall) begin
                    w_pc_redirect = 1'b1;
                    w_ifid_flush  = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_flush_evt   = 1'b1;
                end else if (io_hz.ext_stall) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_stall_evt  = 1'b1;
                    if (io_hz.branch_taken) begin
                        w_next_state = ST_HOLD_RD;
                        w_pend_next  = io_hz.branch_target;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end else if (w_load_use) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_idex_flush = 1'b1;
                    w_stall_evt  = 1'b1;
                end
            end
            // Frozen with a redirect owed; later branches are ignored
            ST_HOLD_RD: begin
                if (io_hz.ext_stall) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_stall_evt  = 1'b1;
                end else begin
                    w_pc_redirect = 1'b1;
                    w_ifid_flush  = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_flush_evt   = 1'b1;
                    w_next_state  = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase

        // While reset is asserted the pipeline is held and filled with bubbles
        if (!reset) begin
            w_pc_write        = 1'b0;
            w_ifid_write      = 1'b0;
            w_ifid_flush      = 1'b1;
            w_idex_flush      = 1'b1;
            w_pc_redirect     = 1'b0;
            w_redirect_target = '0;
            w_stall_evt       = 1'b0;
            w_flush_evt       = 1'b0;
        end
    end

    assign io_hz.pc_write        = w_pc_write;
    assign io_hz.pc_redirect     = w_pc_redirect;
    assign io_hz.redirect_target = w_redirect_target;
    assign io_hz.ifid_write      = w_ifid_write;
    assign io_hz.ifid_flush      = w_ifid_flush;
    assign io_hz.idex_flush      = w_idex_flush;
    assign io_hz.stall_count     = r_stall_cnt;
    assign io_hz.flush_count     = r_flush_cnt;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifid_hazard_ctrl
// Directed steps followed by random traffic, each cycle compared against a
// reference model that only tracks "is a redirect owed, and to where" plus
// the two event counts. Counters are built 8 bits wide so saturation can be
// reached quickly.
// ---------------------------------------------------------------------------
module tb_ifid_hazard_ctrl;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    ifid_hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) hz ();

    ifid_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .io_hz (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit              m_pend_v;
    logic [XLEN-1:0] m_pend_t;
    int              m_stall;
    int              m_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                         input logic [4:0] rd, input bit mr, input bit bt,
                         input logic [XLEN-1:0] tgt, input bit es);
        hz.ifid_rs1      = rs1;
        hz.ifid_rs2      = rs2;
        hz.ifid_use_rs1  = u1;
        hz.ifid_use_rs2  = u2;
        hz.idex_rd       = rd;
        hz.idex_mem_read = mr;
        hz.branch_taken  = bt;
        hz.branch_target = tgt;
        hz.ext_stall     = es;
    endtask

    // One clock cycle: drive, check outputs against the model, clock, check counters
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input logic [4:0] rd, input bit mr,
                        input bit bt, input logic [XLEN-1:0] tgt, input bit es);
        bit lu;
        bit e_pw, e_iw, e_if, e_xf, e_rd;
        logic [XLEN-1:0] e_tgt;
        bit stall_evt, flush_evt;
        @(negedge clk);
        drive(rs1, rs2, u1, u2, rd, mr, bt, tgt, es);
        lu = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        e_pw = 1; e_iw = 1; e_if = 0; e_xf = 0; e_rd = 0;
        e_tgt = m_pend_v ? m_pend_t : tgt;
        stall_evt = 0; flush_evt = 0;
        if (m_pend_v) begin
            if (es) begin
                e_pw = 0; e_iw = 0; stall_evt = 1;
            end else begin
                e_rd = 1; e_if = 1; e_xf = 1; flush_evt = 1;
            end
        end else if (bt && !es) begin
            e_rd = 1; e_if = 1; e_xf = 1; flush_evt = 1;
        end else if (es) begin
            e_pw = 0; e_iw = 0; stall_evt = 1;
        end else if (lu) begin
            e_pw = 0; e_iw = 0; e_xf = 1; stall_evt = 1;
        end
        #1;
        chk({tag, ".pc_write"},        64'(hz.pc_write),    64'(e_pw));
        chk({tag, ".ifid_write"},      64'(hz.ifid_write),  64'(e_iw));
        chk({tag, ".ifid_flush"},      64'(hz.ifid_flush),  64'(e_if));
        chk({tag, ".idex_flush"},      64'(hz.idex_flush),  64'(e_xf));
        chk({tag, ".pc_redirect"},     64'(hz.pc_redirect), 64'(e_rd));
        chk({tag, ".redirect_target"}, hz.redirect_target,  e_tgt);
        // Model update for the edge that ends this cycle
        if (m_pend_v) begin
            if (!es) m_pend_v = 0;
        end else if (es && bt) begin
            m_pend_v = 1;
            m_pend_t = tgt;
        end
        if (stall_evt && m_stall < CNT_MAX) m_stall++;
        if (flush_evt && m_flush < CNT_MAX) m_flush++;
        @(posedge clk);
        #1;
        chk({tag, ".stall_count"}, 64'(hz.stall_count), 64'(m_stall));
        chk({tag, ".flush_count"}, 64'(hz.flush_count), 64'(m_flush));
    endtask

    task automatic idle(input string tag);
        step(tag, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'h0, 0);
    endtask

    // Assert reset for n rising edges while a non-zero branch target is presented
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'hDEAD_BEEF, 0);
        m_pend_v = 0; m_pend_t = '0; m_stall = 0; m_flush = 0;
        #1;
        chk("rst.pc_write",        64'(hz.pc_write),    64'd0);
        chk("rst.ifid_write",      64'(hz.ifid_write),  64'd0);
        chk("rst.ifid_flush",      64'(hz.ifid_flush),  64'd1);
        chk("rst.idex_flush",      64'(hz.idex_flush),  64'd1);
        chk("rst.pc_redirect",     64'(hz.pc_redirect), 64'd0);
        chk("rst.redirect_target", hz.redirect_target,  64'd0);
        repeat (n) @(posedge clk);
        #1;
        chk("rst.stall_count", 64'(hz.stall_count), 64'd0);
        chk("rst.flush_count", 64'(hz.flush_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel.pc_write",   64'(hz.pc_write),   64'd1);
        chk("rel.ifid_write", 64'(hz.ifid_write), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'h0, 0);
        m_pend_v = 0; m_pend_t = '0; m_stall = 0; m_flush = 0;

        // Reset held for three cycles, then release
        do_reset(3);
        idle("idle0");

        // Load-use on rs1, then the same with rd = x0 (no hazard), then on rs2
        step("lu_rs1",  5'd5, 5'd7, 1, 1, 5'd5, 1, 0, 64'h0, 0);
        chk("lu_rs1.cnt", 64'(hz.stall_count), 64'd1);
        step("lu_x0",   5'd0, 5'd7, 1, 1, 5'd0, 1, 0, 64'h0, 0);
        step("lu_rs2",  5'd3, 5'd9, 1, 1, 5'd9, 1, 0, 64'h0, 0);
        step("lu_nouse",5'd9, 5'd2, 0, 1, 5'd9, 1, 0, 64'h0, 0);

        // Branch beats load-use in RUN
        step("br_lu", 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 64'h1000, 0);
        chk("br_lu.flush", 64'(hz.flush_count), 64'd1);

        // Four-cycle freeze, branches in cycles 2 and 3, redirect to the first one
        step("fz1", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'h0,    1);
        step("fz2", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 64'h2000, 1);
        step("fz3", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 64'h3000, 1);
        step("fz4", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'h0,    1);
        step("fz5", 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 64'h4000, 0);
        chk("fz.stall", 64'(hz.stall_count), 64'd6);
        chk("fz.flush", 64'(hz.flush_count), 64'd2);
        idle("idle1");

        // Freeze without a branch, then leave HOLD into a load-use
        step("hold1", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'h0, 1);
        step("hold2", 5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 64'h0, 0);

        // Long freeze saturates the stall counter
        for (int i = 0; i < CNT_MAX + 20; i++) step("sat", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'h0, 1);
        chk("sat.value", 64'(hz.stall_count), 64'(CNT_MAX));
        idle("idle2");

        // Reset while a redirect is pending discards it
        step("prd1", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 64'h5000, 1);
        step("prd2", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'h0,    1);
        do_reset(2);
        idle("post_rst");
        chk("post_rst.redirect", 64'(hz.pc_redirect), 64'd0);

        // Random traffic with small register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 5'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                 ($urandom_range(99, 0) < 25), {$urandom, $urandom},
                 ($urandom_range(99, 0) < 30));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
